moore_seq_gen: RTL and testbench
================================

# moore_seq_gen

Serial pattern transmitter: the sending end of the single-bit `data` stream consumed by the `moore` sequence detector. It captures a WIDTH-bit pattern and a repeat count on a `start` request, then shifts the pattern out MSB-first, one bit per `clk` cycle, the requested number of times. It raises a one-cycle `done` pulse when finished. It drives detector benches and the on-chip loopback path; all outputs are Moore outputs decoded from registered state.

## Interface
- `WIDTH`, 4: pattern length in bits (≥2)
- `CNT_W`, 4: width of the repeat count
- `GAP`, 2: idle bits between repeats (used only when `MOORE_SEQ_GEN_GAP_EN` is defined; ≥1)

- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `pattern`  in  WIDTH  bits to send; captured with `start`
- `repeat_n`  in  CNT_W  number of transmissions; 0 is treated as 1
- `data`  out  1  serial bit, MSB of the shift register
- `valid`  out  1  `data` carries a pattern bit this cycle
- `busy`  out  1  transmission in progress (SHIFT or GAP)
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SHIFT, GAP (present only with the macro), DONE.
- IDLE: `data`=0, `valid`=0, `busy`=0, `done`=0. When `start`=1, capture `pattern` into the shift register and a hold register, load the bit counter with WIDTH-1, and load the repeat counter with max(`repeat_n`,1). Go to SHIFT.
- SHIFT: `data`=shreg[WIDTH-1], `valid`=1, `busy`=1. Shift left by one each cycle, filling with 0.
  - When the bit counter is 0 and repeats remain >1: decrement the repeat counter and reload the shift register from the hold register. The next state is SHIFT (back-to-back), or GAP when the macro is defined.
  - When the bit counter is 0 and the repeat counter is 1: go to DONE.
- GAP: `data`=0, `valid`=0, `busy`=1 for exactly GAP cycles, then SHIFT.
- DONE: `done`=1, `busy`=0, `valid`=0, `data`=0 for one cycle, then IDLE.
- `start` outside IDLE (including DONE) is ignored. Captured `pattern`/`repeat_n` are immune to later input changes.
- Counter arithmetic is unsigned. The bit counter is clog2(WIDTH) wide. The repeat counter is CNT_W wide and never wraps: it is loaded ≥1 and decremented only while >1.

## Timing
- Reset value of every output is 0; the state is IDLE. `reset` overrides `start` in the same cycle.
- `reset` mid-operation: at the next edge the state is IDLE, all outputs are 0, and any partial pattern is abandoned. No `done` is issued.
- Latency: `start` sampled at edge k → first bit valid in the cycle after edge k.
- Duration: R·WIDTH valid cycles (R = effective repeats), plus (R−1)·GAP gap cycles with the macro. `done` follows the last bit in the very next cycle.
- Minimum `start`-to-`start` spacing is the duration plus 2 cycles: DONE, then IDLE sampling.

## Configuration
- `MOORE_SEQ_GEN_GAP_EN` defined: GAP state and gap counter compiled in. GAP zero bits with `valid`=0 are inserted between repeats, never after the last repeat.
- Undefined: no GAP state and no gap counter. Repeats are sent back-to-back with `valid` continuously 1. The `GAP` parameter is ignored.

## Structure
- Shared package `moore_seq_pkg`: state encoding constants (IDLE=0, SHIFT=1, GAP=2, DONE=3) and defaults for WIDTH/CNT_W/GAP. The `moore` detector's target pattern constant is also placed here, so the generator and detector share it.
- One sub-module: `seq_shift_reg`, a parallel-load, shift-left register with MSB out (ports: `clk`, `reset`, `load`, `shift`, `din[WIDTH]`, `msb`).
- Top level holds the FSM, bit, repeat and gap counters, and output decode.

## Test plan
- WIDTH=4, `pattern`=4'b1011, `repeat_n`=1, start at edge 0 → `data` 1,0,1,1 with `valid`=1 in cycles 1–4. `done`=1 only in cycle 5. IDLE in cycle 6.
- Same pattern, `repeat_n`=3, macro off → 12 contiguous valid bits 1011_1011_1011, then `done`. Macro on, GAP=2 → 1011,00,1011,00,1011 with `valid`=0 on the 0s, then `done`.
- `repeat_n`=0 → exactly one 4-bit transmission and one `done` pulse.
- `start` held high throughout plus a pattern change mid-transmission → no restart, original bits sent. New capture only on the IDLE cycle after DONE.
- `reset` asserted in the cycle showing bit 2 → next cycle `data`=`valid`=`busy`=`done`=0. No `done` pulse afterwards.
- Loopback into `moore` with the package target pattern, `repeat_n`=2 → detector `out` asserts once per repeat at the detector's documented latency.

Source files
------------

// File: rtl/moore_seq_pkg.sv
// Shared definitions for the moore serial pattern generator and the moore sequence detector:
// state encoding, parameter defaults and the common target pattern.
package moore_seq_pkg;

    localparam int unsigned DefWidth = 4;
    localparam int unsigned DefCntW  = 4;
    localparam int unsigned DefGap   = 2;

    // Pattern the detector looks for; the generator's loopback stimulus uses the same value.
    localparam logic [DefWidth-1:0] MooreTarget = 4'b1011;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StGap   = 2'd2,
        StDone  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/seq_shift_reg.sv
// Parallel-load, shift-left register with the MSB as the serial output; load wins over shift.
module seq_shift_reg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             msb_o
);

    logic [WIDTH-1:0] shreg_q, shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = din_i;
        end else if (shift_i) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign msb_o = shreg_q[WIDTH-1];

endmodule

// File: rtl/moore_seq_gen.sv
// Serial pattern transmitter: sends a captured pattern MSB-first a given number of times.
// Define MOORE_SEQ_GEN_GAP_EN to insert GAP idle bits between repeats.
module moore_seq_gen
    import moore_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned CNT_W = DefCntW,
    parameter int unsigned GAP   = DefGap
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] pattern_i,
    input  logic [CNT_W-1:0] repeat_n_i,
    output logic             data_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned BitW = $clog2(WIDTH);
    localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);

    if (WIDTH < 2) begin : g_chk_width
        $error("moore_seq_gen: WIDTH must be at least 2");
    end
    if (GAP < 1) begin : g_chk_gap
        $error("moore_seq_gen: GAP must be at least 1");
    end

    seq_state_e       state_q, state_d;
    logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             sr_load, sr_shift, sr_msb;
    logic [WIDTH-1:0] sr_din;

`ifdef MOORE_SEQ_GEN_GAP_EN
    localparam int unsigned GapW = $clog2(GAP + 1);
    localparam logic [GapW-1:0] GapLast = GapW'(GAP - 1);
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
`endif

    seq_shift_reg #(
        .WIDTH(WIDTH)
    ) u_shreg (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .load_i (sr_load),
        .shift_i(sr_shift),
        .din_i  (sr_din),
        .msb_o  (sr_msb)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rep_cnt_d = rep_cnt_q;
        hold_d    = hold_q;
        sr_load   = 1'b0;
        sr_shift  = 1'b0;
        sr_din    = pattern_i;
`ifdef MOORE_SEQ_GEN_GAP_EN
        gap_cnt_d = gap_cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    sr_load   = 1'b1;
                    hold_d    = pattern_i;
                    bit_cnt_d = BitLast;
                    rep_cnt_d = (repeat_n_i == '0) ? CNT_W'(1) : repeat_n_i;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (bit_cnt_q != '0) begin
                    sr_shift  = 1'b1;
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end else if (rep_cnt_q > CNT_W'(1)) begin
                    // Reload here so the register is ready whether or not a gap follows.
                    sr_load   = 1'b1;
                    sr_din    = hold_q;
                    bit_cnt_d = BitLast;
                    rep_cnt_d = rep_cnt_q - 1'b1;
`ifdef MOORE_SEQ_GEN_GAP_EN
                    gap_cnt_d = GapLast;
                    state_d   = StGap;
`endif
                end else begin
                    state_d = StDone;
                end
            end
`ifdef MOORE_SEQ_GEN_GAP_EN
            StGap: begin
                if (gap_cnt_q == '0) begin
                    state_d = StShift;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            hold_q    <= hold_d;
        end
    end

`ifdef MOORE_SEQ_GEN_GAP_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            gap_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end
`endif

    always_comb begin
        data_o  = 1'b0;
        valid_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            StShift: begin
                data_o  = sr_msb;
                valid_o = 1'b1;
                busy_o  = 1'b1;
            end
            StGap: begin
                busy_o = 1'b1;
            end
            StDone: begin
                done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_moore_seq_gen.sv
// Self-checking bench for moore_seq_gen: directed scenarios followed by random traffic,
// compared cycle by cycle against a queue of expected {data, valid, busy, done} words.
module tb_moore_seq_gen;

    localparam int unsigned Width = 4;
    localparam int unsigned CntW  = 4;
    localparam int unsigned Gap   = 2;
`ifdef MOORE_SEQ_GEN_GAP_EN
    localparam bit GapEn = 1'b1;
`else
    localparam bit GapEn = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             start;
    logic [Width-1:0] pattern;
    logic [CntW-1:0]  repeat_n;
    logic             data, valid, busy, done;

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;

    // Expected output word per upcoming cycle; empty means idle (all zeros).
    logic [3:0] exp_q[$];

    moore_seq_gen #(
        .WIDTH(Width),
        .CNT_W(CntW),
        .GAP  (Gap)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .start_i   (start),
        .pattern_i (pattern),
        .repeat_n_i(repeat_n),
        .data_o    (data),
        .valid_o   (valid),
        .busy_o    (busy),
        .done_o    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got {d,v,b,done}=%b expected %b", tag, cycle, obs, exp);
        end
    endtask

    // Whole transmission as a list of cycles: R patterns, gaps only between them, then done.
    task automatic push_transfer(input logic [Width-1:0] pat, input logic [CntW-1:0] rep);
        int r_eff;
        r_eff = (rep == 0) ? 1 : int'(rep);
        for (int r = 0; r < r_eff; r++) begin
            for (int b = Width - 1; b >= 0; b--) begin
                exp_q.push_back({pat[b], 1'b1, 1'b1, 1'b0});
            end
            if (GapEn && r < r_eff - 1) begin
                for (int g = 0; g < int'(Gap); g++) exp_q.push_back(4'b0010);
            end
        end
        exp_q.push_back(4'b0001);
    endtask

    // Drive inputs for one cycle, advance the model at the edge, check mid-cycle.
    task automatic step(input string tag, input logic rst, input logic st,
                        input logic [Width-1:0] pat, input logic [CntW-1:0] rep);
        logic [3:0] exp;
        reset    = rst;
        start    = st;
        pattern  = pat;
        repeat_n = rep;
        @(posedge clk);
        cycle++;
        if (rst) begin
            exp_q.delete();
        end else if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end else if (st) begin
            push_transfer(pat, rep);
        end
        @(negedge clk);
        exp = (exp_q.size() != 0) ? exp_q[0] : 4'b0000;
        check_eq(tag, {data, valid, busy, done}, exp);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        pattern  = '0;
        repeat_n = '0;
        @(negedge clk);

        step("reset", 1'b1, 1'b0, 4'b0000, 4'd0);
        step("reset_start", 1'b1, 1'b1, 4'b1111, 4'd2);
        step("idle", 1'b0, 1'b0, 4'b0000, 4'd0);

        // Single transmission of 1011.
        step("single_start", 1'b0, 1'b1, 4'b1011, 4'd1);
        for (int i = 0; i < 7; i++) step("single", 1'b0, 1'b0, 4'b0000, 4'd0);

        // Three repeats with start held high and the pattern input changing underneath.
        step("rep3_start", 1'b0, 1'b1, 4'b1011, 4'd3);
        for (int i = 0; i < 22; i++) begin
            step("rep3_hold", 1'b0, 1'b1, 4'($urandom), 4'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 30; i++) step("rep3_drain", 1'b0, 1'b0, 4'b0000, 4'd0);

        // Repeat count of zero behaves as one.
        step("rep0_start", 1'b0, 1'b1, 4'b1011, 4'd0);
        for (int i = 0; i < 7; i++) step("rep0", 1'b0, 1'b0, 4'b0000, 4'd0);

        // Reset while bit 2 is on the line abandons the transfer without done.
        step("abort_start", 1'b0, 1'b1, 4'b1011, 4'd2);
        step("abort_bit3", 1'b0, 1'b0, 4'b0000, 4'd0);
        step("abort_reset", 1'b1, 1'b0, 4'b0000, 4'd0);
        for (int i = 0; i < 12; i++) step("abort_after", 1'b0, 1'b0, 4'b0000, 4'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step("random", ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
                 4'($urandom), 4'($urandom_range(0, 4)));
        end
        for (int i = 0; i < 40; i++) step("final_drain", 1'b0, 1'b0, 4'b0000, 4'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
